// File: rtl/pit_seq_pkg.sv
// pit_seq_pkg: shared states, opcodes and control-word field values for the i8253 command sequencer
package pit_seq_pkg;
    typedef enum logic [2:0] {IDLE, CW, GAP1, LO, GAP2, HI, DONE} state_t;
    typedef enum logic {OP_PROGRAM, OP_READ} op_t;
    localparam logic [1:0] PIT_CW_ADDR = 2'b11;
    localparam logic [1:0] RL_LATCH    = 2'b00;
    localparam logic [1:0] RL_LSB_MSB  = 2'b11;
endpackage

// File: rtl/pit_seq_gap.sv
// pit_seq_gap: loadable down-counter; done is high in the last cycle of a GAP-cycle idle gap
module pit_seq_gap #(
    parameter int GAP = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic done
);
    localparam int W = GAP > 0 ? $clog2(GAP + 1) : 1;
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (load) cnt <= W'(GAP);
        else if (cnt != '0) cnt <= cnt - W'(1);
    end
    assign done = cnt == W'(1);
endmodule

// File: rtl/pit_sequencer.sv
// pit_sequencer: turns one channel command into i8253 CW/LSB/MSB bus cycles.
// Optional PIT_SEQ_CHKCH_EN rejects cmd_ch==3 with rsp_err instead of running the bus sequence.
module pit_sequencer
    import pit_seq_pkg::*;
#(
    parameter int GAP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [1:0]  cmd_ch,
    input  logic [2:0]  cmd_mode,
    input  logic [15:0] cmd_count,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        pit_cs,
    output logic        pit_rd,
    output logic        pit_wr,
    output logic [1:0]  pit_a,
    output logic [7:0]  pit_dout,
    input  logic [7:0]  pit_din
);
    state_t      state, nxt, first_st;
    op_t         op;
    logic [1:0]  ch;
    logic [2:0]  mode;
    logic [15:0] count;
    logic [7:0]  data_lo;
    logic        accept, gap_done, byte_st, prog;

    assign cmd_ready = state == IDLE && !reset;
    assign accept    = cmd_valid && cmd_ready;

`ifdef PIT_SEQ_CHKCH_EN
    logic err;
    always_ff @(posedge clk) begin
        if (reset) err <= 1'b0;
        else if (accept) err <= cmd_ch == 2'd3;
    end
    assign first_st = cmd_ch == 2'd3 ? DONE : CW;
    assign rsp_err  = state == DONE && err;
`else
    assign first_st = CW;
    assign rsp_err  = 1'b0;
`endif

    pit_seq_gap #(.GAP(GAP)) u_gap (
        .clk  (clk),
        .reset(reset),
        .load (state == CW || state == LO),
        .done (gap_done)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = accept ? first_st : IDLE;
            CW:      nxt = GAP > 0 ? GAP1 : LO;
            GAP1:    nxt = gap_done ? LO : GAP1;
            LO:      nxt = GAP > 0 ? GAP2 : HI;
            GAP2:    nxt = gap_done ? HI : GAP2;
            HI:      nxt = DONE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op       <= OP_PROGRAM;
            ch       <= '0;
            mode     <= '0;
            count    <= '0;
            data_lo  <= '0;
            rsp_data <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                op    <= op_t'(cmd_op);
                ch    <= cmd_ch;
                mode  <= cmd_mode;
                count <= cmd_count;
            end
            if (accept && first_st == DONE) rsp_data <= '0;
            if (state == LO && op == OP_READ) data_lo <= pit_din;
            // MSB is sampled straight off the bus so the result is complete in DONE
            if (state == HI) rsp_data <= op == OP_READ ? {pit_din, data_lo} : 16'h0000;
        end
    end

    assign byte_st   = state == LO || state == HI;
    assign prog      = op == OP_PROGRAM;
    assign pit_cs    = state == CW || byte_st;
    assign pit_wr    = state == CW || (byte_st && prog);
    assign pit_rd    = byte_st && !prog;
    assign pit_a     = state == CW ? PIT_CW_ADDR : byte_st ? ch : 2'b00;
    assign pit_dout  = state == CW ? (prog ? {ch, RL_LSB_MSB, mode, 1'b0} : {ch, RL_LATCH, 4'b0000})
                     : (byte_st && prog) ? (state == LO ? count[7:0] : count[15:8]) : 8'h00;
    assign rsp_valid = state == DONE;
endmodule

// File: tb/tb_pit_sequencer.sv
// tb_pit_sequencer: directed table-driven checks of the i8253 command sequencer (GAP=1 and GAP=0 instances)
module tb_pit_sequencer;
    logic        clk = 1'b0, reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_op = 1'b0;
    logic [1:0]  cmd_ch = '0;
    logic [2:0]  cmd_mode = '0;
    logic [15:0] cmd_count = '0;
    logic [7:0]  din0 = '0;
    logic        rdy0, rv0, err0, cs0, rd0, wr0;
    logic [15:0] rdata0;
    logic [1:0]  a0;
    logic [7:0]  dout0;
    logic        rdy1, rv1, err1, cs1, rd1, wr1;
    logic [15:0] rdata1;
    logic [1:0]  a1;
    logic [7:0]  dout1;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    pit_sequencer #(.GAP(1)) u0 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy0), .cmd_op(cmd_op),
        .cmd_ch(cmd_ch), .cmd_mode(cmd_mode), .cmd_count(cmd_count), .rsp_valid(rv0),
        .rsp_data(rdata0), .rsp_err(err0), .pit_cs(cs0), .pit_rd(rd0), .pit_wr(wr0),
        .pit_a(a0), .pit_dout(dout0), .pit_din(din0)
    );

    pit_sequencer #(.GAP(0)) u1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy1), .cmd_op(cmd_op),
        .cmd_ch(cmd_ch), .cmd_mode(cmd_mode), .cmd_count(cmd_count), .rsp_valid(rv1),
        .rsp_data(rdata1), .rsp_err(err1), .pit_cs(cs1), .pit_rd(rd1), .pit_wr(wr1),
        .pit_a(a1), .pit_dout(dout1), .pit_din(8'h00)
    );

    typedef struct {
        logic        op;
        logic [1:0]  ch;
        logic [2:0]  mode;
        logic [15:0] count;
        logic [7:0]  din_lo;
        logic [7:0]  din_hi;
        logic [7:0]  cw;
        logic [15:0] rsp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic op, input logic [1:0] ch, input logic [2:0] mode, input logic [15:0] cnt);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ch    = ch;
        cmd_mode  = mode;
        cmd_count = cnt;
    endtask

    // one command on the GAP=1 instance: cycle k after the accept edge is CW(1) gap(2) LO(3) gap(4) HI(5) DONE(6) IDLE(7)
    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        logic strobe;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        chk({tag, "_ready"}, rdy0, 1);
        drive(v.op, v.ch, v.mode, v.count);
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_count = 16'hDEAD;
            din0 = k == 3 ? v.din_lo : k == 5 ? v.din_hi : 8'h00;
            strobe = k == 1 || k == 3 || k == 5;
            chk($sformatf("%s_k%0d_cs", tag, k), cs0, strobe);
            chk($sformatf("%s_k%0d_wr", tag, k), wr0, k == 1 || (strobe && !v.op));
            chk($sformatf("%s_k%0d_rd", tag, k), rd0, (k == 3 || k == 5) && v.op);
            chk($sformatf("%s_k%0d_a", tag, k), a0, k == 1 ? 3 : strobe ? v.ch : 0);
            chk($sformatf("%s_k%0d_dout", tag, k), dout0,
                k == 1 ? v.cw : (k == 3 && !v.op) ? v.count[7:0] : (k == 5 && !v.op) ? v.count[15:8] : 8'h00);
            chk($sformatf("%s_k%0d_rv", tag, k), rv0, k == 6);
            chk($sformatf("%s_k%0d_err", tag, k), err0, 0);
            chk($sformatf("%s_k%0d_ready", tag, k), rdy0, k == 7);
            if (k >= 6) chk($sformatf("%s_k%0d_rdata", tag, k), rdata0, v.rsp);
        end
    endtask

    initial begin
        int n;
        logic found;
        vecs[0] = '{1'b0, 2'd2, 3'd3, 16'h1234, 8'h00, 8'h00, 8'hB6, 16'h0000};
        vecs[1] = '{1'b1, 2'd0, 3'd0, 16'h0000, 8'hCD, 8'hAB, 8'h00, 16'hABCD};
        vecs[2] = '{1'b0, 2'd0, 3'd2, 16'h0064, 8'h00, 8'h00, 8'h34, 16'h0000};
        vecs[3] = '{1'b0, 2'd1, 3'd0, 16'hFFFF, 8'h00, 8'h00, 8'h70, 16'h0000};
        vecs[4] = '{1'b0, 2'd2, 3'd5, 16'h0001, 8'h00, 8'h00, 8'hBA, 16'h0000};
        vecs[5] = '{1'b1, 2'd1, 3'd0, 16'h0000, 8'h5A, 8'hC3, 8'h40, 16'hC35A};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", rdy0, 0);
        chk("rst_cs", cs0, 0);
        chk("rst_a", a0, 0);
        chk("rst_dout", dout0, 0);
        chk("rst_rv", rv0, 0);
        chk("rst_rdata", rdata0, 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

`ifdef PIT_SEQ_CHKCH_EN
        @(negedge clk);
        drive(1'b0, 2'd3, 3'd1, 16'hBEEF);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("ch3_rv", rv0, 1);
        chk("ch3_err", err0, 1);
        chk("ch3_rdata", rdata0, 0);
        chk("ch3_cs_k1", cs0, 0);
        @(negedge clk);
        chk("ch3_ready", rdy0, 1);
        chk("ch3_cs_k2", cs0, 0);
        chk("ch3_err_k2", err0, 0);
`else
        begin
            vec_t v3;
            v3 = '{1'b0, 2'd3, 3'd1, 16'hBEEF, 8'h00, 8'h00, 8'hF2, 16'h0000};
            run_vec(v3, 6);
        end
`endif

        // reset while the LO strobe is on the bus
        @(negedge clk);
        drive(1'b0, 2'd1, 3'd2, 16'h5555);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_lo_cs", cs0, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_cs", cs0, 0);
        chk("rstmid_wr", wr0, 0);
        chk("rstmid_rd", rd0, 0);
        chk("rstmid_a", a0, 0);
        chk("rstmid_dout", dout0, 0);
        chk("rstmid_rv", rv0, 0);
        chk("rstmid_ready", rdy0, 0);
        reset = 1'b0;
        #1;
        chk("rstmid_ready_after", rdy0, 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("rstmid_rv_%0d", k), rv0, 0);
            chk($sformatf("rstmid_cs_%0d", k), cs0, 0);
        end

        // GAP=0 instance with cmd_valid held: second accept exactly 5 edges after the first
        @(negedge clk);
        drive(1'b0, 2'd0, 3'd3, 16'h0102);
        chk("b2b_ready0", rdy1, 1);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_cw_a", dout1, 8'h36);
        drive(1'b0, 2'd1, 3'd4, 16'h0000);
        n = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            n++;
            if (rdy1) found = 1'b1;
            else @(posedge clk);
        end
        chk("b2b_found", found, 1);
        chk("b2b_period", n, 5);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b_cs_b", cs1, 1);
        chk("b2b_cw_b", dout1, 8'h78);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
